// File: rtl/ram_512_pkg.sv
// Shared sizing for the 512 x 16 frame buffer used in the spectral frequency-shift path.
package ram_512_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/ram_512_array.sv
// Bare storage array: synchronous write port, combinational read port, no reset so it maps to block RAM.
module ram_512_array #(
    parameter int DATA_W = ram_512_pkg::DATA_W,
    parameter int ADDR_W = ram_512_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    input  logic [ADDR_W-1:0] rdaddress,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[wraddress] <= data;
        end
    end

    // Read registers in the parent sample this before the edge's write lands, giving old-data collisions.
    assign rd_data = mem[rdaddress];

endmodule

// File: rtl/ram_512.sv
// Simple dual-port 512 x 16 RAM with registered read; define RAM_512_OUTREG_EN for an extra output register.
module ram_512 #(
    parameter int DATA_W = ram_512_pkg::DATA_W,
    parameter int ADDR_W = ram_512_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic              rden,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rd_p0;
    logic              wr_gated;

    // Writes are blocked for as long as reset is held.
    assign wr_gated = wren & rst_n;

    ram_512_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock     (clock),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wr_gated),
        .rdaddress (rdaddress),
        .rd_data   (rd_data)
    );

    // Stage 0: read register, holds while rden is low.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_p0 <= '0;
        end else if (rden) begin
            rd_p0 <= rd_data;
        end
    end

`ifdef RAM_512_OUTREG_EN
    logic [DATA_W-1:0] out_p1;

    // Stage 1: free-running output register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= '0;
        end else begin
            out_p1 <= rd_p0;
        end
    end

    assign q = out_p1;
`else
    assign q = rd_p0;
`endif

endmodule

// File: tb/tb_ram_512.sv
// Self-checking bench for ram_512: directed test-plan steps plus a randomized phase against a reference model.
module tb_ram_512;
    import ram_512_pkg::*;

`ifdef RAM_512_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    word_t             data = '0;
    logic [ADDR_W-1:0] wraddress = '0;
    logic              wren = 1'b0;
    logic [ADDR_W-1:0] rdaddress = '0;
    logic              rden = 1'b0;
    word_t             q;

    int errors = 0;
    int checks = 0;

    // Reference model: word array plus the history of words captured by reads.
    word_t ref_mem [DEPTH];
    word_t last_read = '0;
    word_t hist [2] = '{16'h0, 16'h0};

    ram_512 dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input word_t expected);
        checks++;
        assert (q === expected)
        else begin
            errors++;
            $error("FAIL %s: q=%h expected=%h", tag, q, expected);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check q #1 after the edge.
    task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input word_t wd,
                        input logic re, input logic [ADDR_W-1:0] ra, input string tag);
        wren = we;
        wraddress = wa;
        data = wd;
        rden = re;
        rdaddress = ra;
        @(posedge clock);
        if (rst_n) begin
            if (re) last_read = ref_mem[ra];
            if (we) ref_mem[wa] = wd;
        end
        hist[1] = hist[0];
        hist[0] = last_read;
        #1;
        check(tag, hist[LAT-1]);
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, '0, 1'b0, '0, tag);
    endtask

    initial begin
        logic [ADDR_W-1:0] wa;
        logic [ADDR_W-1:0] ra;
        word_t             wd;
        logic              we;
        logic              re;

        // Reset state
        #2;
        check("reset_q_t0", 16'h0000);
        step(1'b1, 9'd3, 16'hBEEF, 1'b1, 9'd3, "reset_hold");
        rst_n = 1'b1;

        // Streaming full frame: write 512 words, then read them back to back
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, ADDR_W'(i), word_t'(i) ^ 16'h5A5A, 1'b0, '0, "stream_wr");
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, '0, 1'b1, ADDR_W'(i), "stream_rd");
        end
        for (int i = 0; i < LAT; i++) idle("stream_tail");
        check("stream_last", 16'h01FF ^ 16'h5A5A);

        // Basic write/read at low, high and mid addresses
        step(1'b1, 9'd0,   16'h1234, 1'b0, '0, "basic_wr0");
        step(1'b1, 9'd511, 16'hABCD, 1'b0, '0, "basic_wr511");
        step(1'b1, 9'd256, 16'h0001, 1'b0, '0, "basic_wr256");
        step(1'b0, '0, '0, 1'b1, 9'd0,   "basic_rd0");
        step(1'b0, '0, '0, 1'b1, 9'd511, "basic_rd511");
        step(1'b0, '0, '0, 1'b1, 9'd256, "basic_rd256");
        for (int i = 0; i < LAT; i++) idle("basic_tail");
        check("basic_const256", 16'h0001);

        // Read enable hold
        step(1'b0, '0, '0, 1'b1, 9'd0, "hold_rd0");
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 9'd511, "hold_rden_low");
        check("hold_const", 16'h1234);
        step(1'b0, '0, '0, 1'b1, 9'd511, "hold_rden_high");
        for (int i = 0; i < LAT; i++) idle("hold_tail");
        check("hold_release_const", 16'hABCD);

        // Read-during-write collision at the same address
        step(1'b1, 9'd5, 16'h1111, 1'b0, '0, "coll_init");
        step(1'b1, 9'd5, 16'h2222, 1'b1, 9'd5, "coll_same_edge");
        step(1'b0, '0, '0, 1'b1, 9'd5, "coll_next");
        if (LAT == 2) idle("coll_tail");
        check("coll_new_const", 16'h2222);

        // Async reset mid-cycle with q = 0xABCD
        step(1'b1, 9'd7, 16'h7777, 1'b1, 9'd511, "areset_pre");
        for (int i = 0; i < LAT; i++) idle("areset_settle");
        check("areset_before", 16'hABCD);
        #2;
        rst_n = 1'b0;
        last_read = '0;
        hist = '{16'h0, 16'h0};
        #1;
        check("areset_no_edge", 16'h0000);

        // Write suppressed under reset
        step(1'b1, 9'd7, 16'hFFFF, 1'b1, 9'd7, "supp_wr_in_reset");
        step(1'b1, 9'd7, 16'hFFFF, 1'b0, 9'd7, "supp_wr_in_reset2");
        rst_n = 1'b1;
        step(1'b0, '0, '0, 1'b1, 9'd511, "areset_retained");
        step(1'b0, '0, '0, 1'b1, 9'd7,   "supp_rd7");
        for (int i = 0; i < LAT; i++) idle("supp_tail");
        check("supp_const", 16'h7777);

        // Randomized mix with frequent same-address collisions
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom);
            re = 1'($urandom);
            wa = ADDR_W'($urandom);
            wd = word_t'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom);
            step(we, wa, wd, re, ra, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
